// File: rtl/mprj_pad_cfg_sequencer.sv
// mprj_pad_cfg_sequencer: per-pad config store serialised into the GPIO control shift chain (optional SERIAL_READBACK_EN)
module mprj_pad_cfg_sequencer #(
    parameter int                  NUM_PADS    = 38,
    parameter logic [NUM_PADS-1:0] ANALOG_MASK = {NUM_PADS{1'b0}},
    parameter int                  CFG_BITS    = 13,
    parameter int                  CLK_DIV     = 2,
    parameter logic [CFG_BITS-1:0] CFG_RESET   = CFG_BITS'(13'h0403),
    localparam int                 AW          = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cfg_wr,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [CFG_BITS-1:0] cfg_wdata,
    output logic [CFG_BITS-1:0] cfg_rdata,
    input  logic                xfer_start,
    output logic                busy,
    output logic                done,
    output logic                serial_clock,
    output logic                serial_load,
    output logic                serial_data_out,
    input  logic                serial_data_in,
    output logic                readback_err
);
    function automatic int zeros_below(input logic [NUM_PADS-1:0] mask, input int n);
        int c;
        c = 0;
        for (int j = 0; j < n; j++) c += mask[j] ? 0 : 1;
        return c;
    endfunction

    localparam int ND    = zeros_below(ANALOG_MASK, NUM_PADS);
    localparam int NBITS = ND * CFG_BITS;
    localparam int IW    = (NBITS > 0) ? NBITS : 1;
    localparam int CW    = (NBITS > 0) ? $clog2(NBITS + 1) : 1;
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST  = CW'((NBITS > 0) ? NBITS - 1 : 0);
    localparam logic [DW-1:0] DLAST = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, LOAD} state_t;

    state_t                             state_q, state_d;
    logic   [DW-1:0]                    div_q, div_d;
    logic   [CW-1:0]                    bit_q, bit_d;
    logic   [IW-1:0]                    sh_q, sh_d;
    logic                               sdo_q, sdo_d;
    logic   [NUM_PADS-1:0][CFG_BITS-1:0] word;
    logic   [IW-1:0]                    img;
    logic                               div_end;

    // Image is packed with the lowest digital pad at the LSB end, so the
    // MSB of the image is the first bit shifted out.
    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
        if (ANALOG_MASK[i]) begin : g_ana
            assign word[i] = '0;
        end else begin : g_dig
            localparam int P = zeros_below(ANALOG_MASK, i);
            logic [CFG_BITS-1:0] word_q;
            // Store write, blocked during a transfer so the image stays frozen
            always_ff @(posedge clk or negedge resetn)
                if (!resetn) word_q <= CFG_RESET;
                else if (cfg_wr && !busy && cfg_addr == AW'(i)) word_q <= cfg_wdata;
            assign word[i] = word_q;
            assign img[P*CFG_BITS +: CFG_BITS] = word_q;
        end
    end
    if (NBITS == 0) begin : g_empty
        assign img = '0;
    end

    assign cfg_rdata       = (32'(cfg_addr) < NUM_PADS) ? word[cfg_addr] : '0;
    assign div_end         = div_q == DLAST;
    assign busy            = state_q != IDLE;
    assign serial_clock    = state_q == HIGH;
    assign serial_load     = state_q == LOAD;
    assign done            = (state_q == LOAD) && div_end;
    assign serial_data_out = sdo_q;

    // Sequencer state register
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            sdo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            sdo_q   <= sdo_d;
        end

    // Next state: data only changes when entering LOW (or clears entering LOAD)
    always_comb begin
        state_d = state_q;
        div_d   = (state_q == IDLE || div_end) ? '0 : div_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        sdo_d   = sdo_q;
        case (state_q)
            IDLE: if (xfer_start) begin
                state_d = (NBITS == 0) ? LOAD : LOW;
                bit_d   = '0;
                sdo_d   = img[IW-1];
                sh_d    = img << 1;
            end
            LOW:  if (div_end) state_d = HIGH;
            HIGH: if (div_end) begin
                if (bit_q == LAST) begin
                    state_d = LOAD;
                    sdo_d   = 1'b0;
                end else begin
                    state_d = LOW;
                    bit_d   = bit_q + 1'b1;
                    sdo_d   = sh_q[IW-1];
                    sh_d    = sh_q << 1;
                end
            end
            LOAD: if (div_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef SERIAL_READBACK_EN
    logic [IW-1:0] shadow_q;
    logic          valid_q, err_q;
    logic          sample;

    // The clk edge that ends the last LOW cycle is the serial_clock rise
    assign sample = (state_q == LOW) && div_end;

    // Shadow rotates once per compared bit, so after a full transfer it is
    // back in place before being replaced with the freshly loaded image
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            shadow_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (state_q == IDLE && xfer_start) err_q <= 1'b0;
            else if (sample && valid_q && serial_data_in != shadow_q[IW-1]) err_q <= 1'b1;
            if (done) begin
                shadow_q <= img;
                valid_q  <= 1'b1;
            end else if (sample) shadow_q <= (shadow_q << 1) | (shadow_q >> (IW - 1));
        end
    assign readback_err = err_q;
`else
    logic unused_sdi;
    assign unused_sdi   = serial_data_in;
    assign readback_err = 1'b0;
`endif
endmodule

// File: tb/tb_mprj_pad_cfg_sequencer.sv
// tb_mprj_pad_cfg_sequencer: directed checks of store, serial stream, timing, abort and readback
module tb_mprj_pad_cfg_sequencer;
`ifdef SERIAL_READBACK_EN
    localparam logic RB = 1'b1;
`else
    localparam logic RB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [2:0] cfg_addr = 3'd0;
    logic [3:0] cfg_wdata = 4'd0;
    logic [3:0] cfg_rdata;
    logic       xfer_start = 1'b0;
    logic       busy, done, sclk, sload, sdo, rerr, sdi;
    logic       xs2 = 1'b0;
    logic [3:0] e_rdata;
    logic       e_busy, e_done, e_sclk, e_sload, e_sdo, e_rerr;

    logic [23:0] sr = '0;
    int          rise_cnt = 0, busy_cnt = 0, load_cnt = 0, load_bad = 0, done_busy = 0, e_rise = 0;
    logic        flip_en = 1'b0;
    int          flip_at = 0;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    mprj_pad_cfg_sequencer #(
        .NUM_PADS(8), .ANALOG_MASK(8'b0011_0000), .CFG_BITS(4), .CLK_DIV(2), .CFG_RESET(4'h3)
    ) u_dut (
        .clk(clk), .resetn(resetn), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata), .xfer_start(xfer_start), .busy(busy), .done(done),
        .serial_clock(sclk), .serial_load(sload), .serial_data_out(sdo),
        .serial_data_in(sdi), .readback_err(rerr)
    );

    mprj_pad_cfg_sequencer #(
        .NUM_PADS(8), .ANALOG_MASK(8'hFF), .CFG_BITS(4), .CLK_DIV(1), .CFG_RESET(4'h3)
    ) u_edge (
        .clk(clk), .resetn(resetn), .cfg_wr(1'b0), .cfg_addr(3'd0), .cfg_wdata(4'd0),
        .cfg_rdata(e_rdata), .xfer_start(xs2), .busy(e_busy), .done(e_done),
        .serial_clock(e_sclk), .serial_load(e_sload), .serial_data_out(e_sdo),
        .serial_data_in(1'b0), .readback_err(e_rerr)
    );

    assign sdi = sr[23] ^ (flip_en && rise_cnt == flip_at);

    always @(posedge sclk) begin
        sr <= {sr[22:0], sdo};
        rise_cnt <= rise_cnt + 1;
    end

    always @(posedge e_sclk) e_rise <= e_rise + 1;

    always @(negedge clk) begin
        if (busy) busy_cnt <= busy_cnt + 1;
        if (done) done_busy <= busy_cnt + 1;
        if (sload) load_cnt <= load_cnt + 1;
        if (sload && sdo) load_bad <= load_bad + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] d);
        cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
        step();
        cfg_wr = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [3:0] exp);
        cfg_addr = a;
        #1;
        chk(tag, 32'(cfg_rdata), 32'(exp));
    endtask

    task automatic pulse_start;
        xfer_start = 1'b1;
        step();
        xfer_start = 1'b0;
        chk("start_busy", 32'(busy), 1);
    endtask

    // Runs a transfer from the current cycle; returns one cycle after done
    task automatic xfer(input string tag, input logic [23:0] exp, input bit poke);
        int b_rise, b_busy, b_load;
        bit got_done;
        b_rise = rise_cnt; b_busy = busy_cnt; b_load = load_cnt;
        pulse_start();
        if (poke) begin
            repeat (10) step();
            cfg_wr = 1'b1; cfg_addr = 3'd0; cfg_wdata = 4'h7; xfer_start = 1'b1;
            step();
            cfg_wr = 1'b0; xfer_start = 1'b0;
        end
        got_done = 1'b0;
        for (int i = 0; i < 400 && !got_done; i++) begin
            @(negedge clk);
            got_done = done;
        end
        chk({tag, "_done_seen"}, 32'(got_done), 1);
        step();
        chk({tag, "_rises"}, 32'(rise_cnt - b_rise), 24);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt - b_busy), 98);
        chk({tag, "_done_at"}, 32'(done_busy - b_busy), 98);
        chk({tag, "_load_cycles"}, 32'(load_cnt - b_load), 2);
        chk({tag, "_stream"}, 32'(sr), 32'(exp));
        chk({tag, "_busy_low"}, 32'(busy), 0);
    endtask

    initial begin
        int b_load;
        repeat (3) step();
        resetn = 1'b1;
        step();
        chk("rst_outs", {26'd0, busy, done, sclk, sload, sdo, rerr}, 0);
        chk("rst_edge_outs", {26'd0, e_busy, e_done, e_sclk, e_sload, e_sdo, e_rerr}, 0);
        for (int a = 0; a < 8; a++)
            rd("rst_rd", 3'(a), (a == 4 || a == 5) ? 4'h0 : 4'h3);

        wr(3'd7, 4'hA); wr(3'd6, 4'h5); wr(3'd3, 4'hF);
        wr(3'd2, 4'h0); wr(3'd1, 4'hC); wr(3'd0, 4'h1);
        wr(3'd5, 4'h9);
        rd("analog_wr_dropped", 3'd5, 4'h0);
        rd("rd_pad7", 3'd7, 4'hA);
        rd("rd_pad1", 3'd1, 4'hC);

        xfer("x1", 24'hA5F0C1, 1'b1);
        rd("busy_wr_dropped", 3'd0, 4'h1);
        chk("x1_rerr", 32'(rerr), 0);

        xfer("x2", 24'hA5F0C1, 1'b0);
        chk("x2_rerr_loop_ok", 32'(rerr), 0);

        flip_en = 1'b1;
        flip_at = rise_cnt + 5;
        xfer("x3", 24'hA5F0C1, 1'b0);
        flip_en = 1'b0;
        chk("x3_rerr_set", 32'(rerr), 32'(RB));
        repeat (3) step();
        chk("x3_rerr_sticky", 32'(rerr), 32'(RB));
        chk("load_sdo_low", 32'(load_bad), 0);

        b_load = load_cnt;
        pulse_start();
        chk("x4_rerr_cleared", 32'(rerr), 0);
        repeat (39) step();
        chk("abort_busy_before", 32'(busy), 1);
        resetn = 1'b0;
        #1;
        chk("abort_outs", {28'd0, busy, sclk, sload, sdo}, 0);
        step(); step();
        resetn = 1'b1;
        step();
        chk("abort_no_load", 32'(load_cnt - b_load), 0);
        rd("abort_store7", 3'd7, 4'h3);
        rd("abort_store0", 3'd0, 4'h3);

        xfer("x5", 24'h333333, 1'b0);
        chk("x5_rerr_suppressed", 32'(rerr), 0);

        xs2 = 1'b1;
        step();
        xs2 = 1'b0;
        chk("edge_busy", 32'(e_busy), 1);
        chk("edge_load", 32'(e_sload), 1);
        chk("edge_done", 32'(e_done), 1);
        chk("edge_sdo", 32'(e_sdo), 0);
        step();
        chk("edge_idle", {30'd0, e_busy, e_done}, 0);
        chk("edge_no_sclk", 32'(e_rise), 0);
        chk("edge_rd_analog", 32'(e_rdata), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
